// File: rtl/uart_tx_serializer_pkg.sv
// rtl/uart_tx_serializer_pkg.sv - shared state encodings, LCR field indices and frame-length helpers
package uart_tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Line control register bit positions
    localparam int LCR_WLEN_LSB = 0;
    localparam int LCR_WLEN_MSB = 1;
    localparam int LCR_STOP     = 2;
    localparam int LCR_PEN      = 3;
    localparam int LCR_EPS      = 4;
    localparam int LCR_STICK    = 5;
    localparam int LCR_BREAK    = 6;

    localparam logic [3:0] TICK_LAST = 4'd15;

    // Index of the final data bit: word length 00 -> 5 bits ... 11 -> 8 bits
    function automatic logic [2:0] last_data_bit(input logic [1:0] wlen);
        return 3'd4 + {1'b0, wlen};
    endfunction

    // Last stop tick counted inside STOP; the IDLE enable that follows is the
    // final tick of the stop bit, so back-to-back frames carry no extra gap.
    function automatic logic [4:0] stop_last_tick(input logic extra_stop, input logic [1:0] wlen);
        if (!extra_stop) begin
            return 5'd14;
        end else if (wlen == 2'b00) begin
            return 5'd22;
        end else begin
            return 5'd30;
        end
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - TX FIFO read-port handshake between FIFO (master) and serializer (slave)
interface uart_tx_serializer_if #(
    parameter int TX_WIDTH = 8
) ();
    logic [TX_WIDTH-1:0] tx_data;
    logic                tx_empty;
    logic                tx_pop;

    modport master (output tx_data, output tx_empty, input tx_pop);
    modport slave  (input tx_data, input tx_empty, output tx_pop);
endinterface

// File: rtl/uart_tx_serializer_parity_calc.sv
// rtl/uart_tx_serializer_parity_calc.sv - parity of the active data bits; stick parity when UART_TX_STICK_PARITY_EN is defined
module uart_parity_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       wlen_i,
    input  logic             pen_i,
    input  logic             eps_i,
    input  logic             stick_i,
    output logic             parity_o
);

    logic parity_even;

`ifndef UART_TX_STICK_PARITY_EN
    logic unused_stick;
    assign unused_stick = stick_i ^ pen_i;
`endif

    // XOR only the bits inside the word length, then apply even/odd/stick selection
    always_comb begin
        parity_even = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < 5 + int'(wlen_i)) begin
                parity_even = parity_even ^ data_i[i];
            end
        end
        parity_o = eps_i ? parity_even : ~parity_even;
`ifdef UART_TX_STICK_PARITY_EN
        if (stick_i && pen_i) begin
            parity_o = ~eps_i;
        end
`endif
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART TX serializer (start, 5-8 data LSB first, parity, 1/1.5/2 stop); optional UART_TX_STICK_PARITY_EN
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int TX_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      wb_rst_ni,
    input  logic                      enable,
    input  logic [7:0]                lcr,
    uart_tx_serializer_if.slave       fifo,
    output logic                      stx_pad_o,
    output logic [2:0]                tstate,
    output logic                      tx_busy
);

    tx_state_e           state_q, state_d;
    logic [3:0]          tick_q, tick_d;
    logic [2:0]          bit_q, bit_d;
    logic [TX_WIDTH-1:0] shift_q, shift_d;
    // Word length, extra stop and parity enable; parity polarity/stick is
    // resolved into par_q at pop time so those bits need not be held.
    logic [3:0]          frame_q, frame_d;
    logic                par_q, par_d;
    logic                line_q, line_d;
    logic                busy_q, busy_d;
    logic                stx_q;
    logic                pop;
    logic                par_bit;
    logic [4:0]          stop_idx;
    logic [4:0]          stop_nxt;
    logic                unused_lcr;

    assign unused_lcr = lcr[7];

    uart_parity_calc #(.WIDTH(TX_WIDTH)) u_parity (
        .data_i   (fifo.tx_data),
        .wlen_i   (lcr[LCR_WLEN_MSB:LCR_WLEN_LSB]),
        .pen_i    (lcr[LCR_PEN]),
        .eps_i    (lcr[LCR_EPS]),
        .stick_i  (lcr[LCR_STICK]),
        .parity_o (par_bit)
    );

    // The stop phase counts up to 32 ticks: bit counter LSB extends the tick counter
    assign stop_idx = {bit_q[0], tick_q};
    assign stop_nxt = stop_idx + 5'd1;

    // Next-state decode; everything advances only on the 16x baud tick
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        frame_d = frame_q;
        par_d   = par_q;
        line_d  = line_q;
        busy_d  = busy_q;
        pop     = 1'b0;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo.tx_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo.tx_data;
                        frame_d = lcr[3:0];
                        par_d   = par_bit;
                        tick_d  = 4'd0;
                        bit_d   = 3'd0;
                        line_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_START;
                    end else begin
                        busy_d  = 1'b0;
                    end
                end
                ST_START: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        line_d  = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = 3'd0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        if (bit_q == last_data_bit(frame_q[LCR_WLEN_MSB:LCR_WLEN_LSB])) begin
                            bit_d = 3'd0;
                            if (frame_q[LCR_PEN]) begin
                                line_d  = par_q;
                                state_d = ST_PARITY;
                            end else begin
                                line_d  = 1'b1;
                                state_d = ST_STOP;
                            end
                        end else begin
                            line_d  = shift_q[0];
                            shift_d = shift_q >> 1;
                            bit_d   = bit_q + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        line_d  = 1'b1;
                        bit_d   = 3'd0;
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    tick_d = stop_nxt[3:0];
                    bit_d  = {2'b00, stop_nxt[4]};
                    if (stop_idx == stop_last_tick(frame_q[LCR_STOP], frame_q[LCR_WLEN_MSB:LCR_WLEN_LSB])) begin
                        tick_d  = 4'd0;
                        bit_d   = 3'd0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; break overrides the line without stopping the FSM
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
            shift_q <= '0;
            frame_q <= 4'd0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            stx_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            frame_q <= frame_d;
            par_q   <= par_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            stx_q   <= line_d & ~lcr[LCR_BREAK];
        end
    end

    assign fifo.tx_pop = pop;
    assign stx_pad_o   = stx_q;
    assign tstate      = state_q;
    assign tx_busy     = busy_q;

endmodule
